ysyx_24100006_axi_rr_read_arbiter: RTL and testbench
====================================================

Name: ysyx_24100006_axi_rr_read_arbiter

Overview:
Shares the single AXI4 read port of the memory/SRAM slave between the IFU (master 0) and the LSU (master 1).
- Arbitration is round-robin. A grant is held for a whole burst.
- Beats are counted against the granted ARLEN, and an error pulse is raised on an RLAST mismatch.
- LSU reads are held off while LSU writes are outstanding, which preserves store-to-load ordering.
- It sits between the core's AXI masters and the memory-side AXI slave. The write channel passes through elsewhere; this block only observes it.

Parameters:
WCNT_W, 4, width of the outstanding-write counter (max 2^WCNT_W-1 in flight)
RST_LAST, 1'b1, reset value of last_grant (1 = LSU, so IFU wins the first tie)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
{ifu,lsu}_arvalid  in  1  per-master read-address valid
{ifu,lsu}_arready  out  1  per-master read-address ready
{ifu,lsu}_araddr  in  32  per-master read address
{ifu,lsu}_arlen  in  8  per-master burst length-1
{ifu,lsu}_arsize  in  3  per-master beat size
{ifu,lsu}_rvalid  out  1  per-master read-data valid
{ifu,lsu}_rready  in  1  per-master read-data ready
{ifu,lsu}_rdata  out  32  per-master read data
{ifu,lsu}_rresp  out  2  per-master read response
{ifu,lsu}_rlast  out  1  per-master last beat
sram_arvalid/arready/araddr/arlen/arsize  out/in/out/out/out  1/1/32/8/3  slave read-address channel
sram_rvalid/rready/rdata/rresp/rlast  in/out/in/in/in  1/1/32/2/1  slave read-data channel
lsu_awvalid, lsu_awready, lsu_bvalid, lsu_bready  in  1 each  write-channel handshakes, observed only
rd_busy  out  1  high in ADDR or DATA
rlast_err  out  1  one-cycle pulse on a beat-count/RLAST mismatch

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, grant=none, last_grant=RST_LAST, beat_cnt=0, wr_cnt=0.
  - All outputs 0. Per-master rdata is 0 unless granted.
- wr_cnt:
  - +1 on lsu_awvalid&lsu_awready; -1 on lsu_bvalid&lsu_bready; no change when both occur in the same cycle.
  - Saturates at max and at 0; never wraps.
- LSU eligibility: lsu_elig = lsu_arvalid & (wr_cnt==0). The IFU is always eligible.
- IDLE:
  - If exactly one master is eligible, grant it.
  - If both are eligible, grant the master != last_grant.
  - The grant register is loaded and state moves to ADDR on the next edge, so arbitration latency is 1 cycle. No slave signals are driven in IDLE.
- ADDR:
  - sram_ar* = granted master's ar*. Granted arready = sram_arready; the other master sees arready=0.
  - On sram_arvalid&sram_arready: beat_cnt<=sram_arlen, go to DATA.
  - A master dropping arvalid before the handshake is a protocol violation; the block stays in ADDR.
- DATA:
  - Granted r* = sram_r*; sram_rready = granted rready. The non-granted master sees rvalid=0, rlast=0, rresp=0, rdata=0.
  - Each beat (sram_rvalid&sram_rready): beat_cnt decrements if nonzero.
  - On a beat with sram_rlast=1: go to IDLE, last_grant<=grant, grant<=none.
  - If sram_rlast=1 while beat_cnt!=0, pulse rlast_err and still terminate.
  - If a beat arrives with beat_cnt==0 and rlast=0, pulse rlast_err and stay in DATA until rlast.
- Grant is never revoked mid-burst. New requests are ignored until IDLE.
- wr_cnt is not rechecked after an LSU grant. A write accepted during an LSU read does not abort that read.
- IDLE-to-IDLE round trip minimum: 1 (arb) + 1 (AR handshake) + beats cycles.

Test Plan:
1. IFU-only: arvalid, araddr=0x80000000, arlen=0; slave responds one beat rdata=0xDEADBEEF, rlast=1 -> ifu_rdata=0xDEADBEEF with ifu_rvalid for 1 cycle; back in IDLE the cycle after; lsu_rvalid stays 0 throughout.
2. Simultaneous requests after reset -> IFU granted first. With both held asserted, grants alternate IFU, LSU, IFU, LSU over 4 transactions.
3. Burst: LSU arlen=3, slave returns 4 beats with rlast on beat 4 -> 4 LSU beats delivered, rlast_err stays 0, IFU request pending throughout is granted only after beat 4.
4. Ordering: LSU completes an AW handshake (wr_cnt=1), then raises arvalid -> no LSU grant until the B handshake. Grant occurs 1 cycle after bvalid&bready. A pending IFU request is served meanwhile.
5. Mismatch: arlen=1, slave asserts rlast on beat 1 -> rlast_err pulses 1 cycle and state returns to IDLE. Separately, arlen=0 with rlast missing on beat 1 -> rlast_err pulse, and the block waits for rlast.
6. Asynchronous reset asserted in DATA mid-burst -> all outputs 0 immediately without a clock edge; after release, the first tie goes to the IFU.

Source files
------------

// File: rtl/ysyx_24100006_axi_rr_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between the IFU (master 0) and LSU (master 1).
// Holds each grant for a whole burst, checks RLAST against ARLEN, and holds off LSU reads while LSU writes are outstanding.
module ysyx_24100006_axi_rr_read_arbiter #(
    parameter int   WCNT_W   = 4,
    parameter logic RST_LAST = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [31:0] ifu_araddr,
    input  logic [7:0]  ifu_arlen,
    input  logic [2:0]  ifu_arsize,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,

    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [31:0] lsu_araddr,
    input  logic [7:0]  lsu_arlen,
    input  logic [2:0]  lsu_arsize,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rlast,

    output logic        sram_arvalid,
    input  logic        sram_arready,
    output logic [31:0] sram_araddr,
    output logic [7:0]  sram_arlen,
    output logic [2:0]  sram_arsize,
    input  logic        sram_rvalid,
    output logic        sram_rready,
    input  logic [31:0] sram_rdata,
    input  logic [1:0]  sram_rresp,
    input  logic        sram_rlast,

    input  logic        lsu_awvalid,
    input  logic        lsu_awready,
    input  logic        lsu_bvalid,
    input  logic        lsu_bready,

    output logic        rd_busy,
    output logic        rlast_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [1:0]        grant, grant_next;        // one-hot: bit 0 IFU, bit 1 LSU, 0 = none
    logic              last_grant, last_grant_next;
    logic [7:0]        beat_cnt, beat_cnt_next;
    logic              rlast_err_next;
    logic [WCNT_W-1:0] wr_cnt;

    logic aw_fire, b_fire, lsu_elig, ar_fire, r_fire;

    assign aw_fire  = lsu_awvalid && lsu_awready;
    assign b_fire   = lsu_bvalid && lsu_bready;
    assign lsu_elig = lsu_arvalid && (wr_cnt == '0);
    assign ar_fire  = sram_arvalid && sram_arready;
    assign r_fire   = sram_rvalid && sram_rready;
    assign rd_busy  = (state != IDLE);

    // Outstanding LSU writes; an AW and a B in the same cycle cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt <= '0;
        end else if (aw_fire && !b_fire && (wr_cnt != '1)) begin
            wr_cnt <= wr_cnt + WCNT_W'(1);
        end else if (b_fire && !aw_fire && (wr_cnt != '0)) begin
            wr_cnt <= wr_cnt - WCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= RST_LAST;
            beat_cnt   <= 8'd0;
            rlast_err  <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            beat_cnt   <= beat_cnt_next;
            rlast_err  <= rlast_err_next;
        end
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        beat_cnt_next   = beat_cnt;
        rlast_err_next  = 1'b0;

        ifu_arready  = 1'b0;
        lsu_arready  = 1'b0;
        ifu_rvalid   = 1'b0;
        ifu_rdata    = 32'd0;
        ifu_rresp    = 2'd0;
        ifu_rlast    = 1'b0;
        lsu_rvalid   = 1'b0;
        lsu_rdata    = 32'd0;
        lsu_rresp    = 2'd0;
        lsu_rlast    = 1'b0;
        sram_arvalid = 1'b0;
        sram_araddr  = 32'd0;
        sram_arlen   = 8'd0;
        sram_arsize  = 3'd0;
        sram_rready  = 1'b0;

        case (state)
            IDLE: begin
                // On a tie the master that did not win last time is granted.
                if (ifu_arvalid && lsu_elig) begin
                    grant_next = last_grant ? 2'b01 : 2'b10;
                end else if (ifu_arvalid) begin
                    grant_next = 2'b01;
                end else if (lsu_elig) begin
                    grant_next = 2'b10;
                end
                if (ifu_arvalid || lsu_elig) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (grant[0]) begin
                    sram_arvalid = ifu_arvalid;
                    sram_araddr  = ifu_araddr;
                    sram_arlen   = ifu_arlen;
                    sram_arsize  = ifu_arsize;
                    ifu_arready  = sram_arready;
                end else if (grant[1]) begin
                    sram_arvalid = lsu_arvalid;
                    sram_araddr  = lsu_araddr;
                    sram_arlen   = lsu_arlen;
                    sram_arsize  = lsu_arsize;
                    lsu_arready  = sram_arready;
                end
                if (ar_fire) begin
                    beat_cnt_next = sram_arlen;
                    state_next    = DATA;
                end
            end
            DATA: begin
                if (grant[0]) begin
                    ifu_rvalid  = sram_rvalid;
                    ifu_rdata   = sram_rdata;
                    ifu_rresp   = sram_rresp;
                    ifu_rlast   = sram_rlast;
                    sram_rready = ifu_rready;
                end else if (grant[1]) begin
                    lsu_rvalid  = sram_rvalid;
                    lsu_rdata   = sram_rdata;
                    lsu_rresp   = sram_rresp;
                    lsu_rlast   = sram_rlast;
                    sram_rready = lsu_rready;
                end
                // RLAST always ends the burst, even when it disagrees with the beat count.
                if (r_fire) begin
                    if (beat_cnt != 8'd0) begin
                        beat_cnt_next = beat_cnt - 8'd1;
                    end
                    if (sram_rlast) begin
                        state_next      = IDLE;
                        last_grant_next = grant[1];
                        grant_next      = 2'b00;
                        rlast_err_next  = (beat_cnt != 8'd0);
                    end else begin
                        rlast_err_next  = (beat_cnt == 8'd0);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_24100006_axi_rr_read_arbiter.sv
// Directed bench for the round-robin AXI read arbiter; the bench itself plays the SRAM slave.
// Inputs change 1 time unit after a rising edge and outputs are checked 2 units later.
module tb_ysyx_24100006_axi_rr_read_arbiter;

    logic        clk;
    logic        reset_n;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_rresp;
    logic        sram_arvalid, sram_arready, sram_rvalid, sram_rready, sram_rlast;
    logic [31:0] sram_araddr, sram_rdata;
    logic [7:0]  sram_arlen;
    logic [2:0]  sram_arsize;
    logic [1:0]  sram_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_bvalid, lsu_bready;
    logic        rd_busy, rlast_err;

    int vectors;
    int miscompares;

    ysyx_24100006_axi_rr_read_arbiter #(.WCNT_W(4), .RST_LAST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid),
        .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
        .sram_arvalid(sram_arvalid), .sram_arready(sram_arready), .sram_araddr(sram_araddr),
        .sram_arlen(sram_arlen), .sram_arsize(sram_arsize), .sram_rvalid(sram_rvalid),
        .sram_rready(sram_rready), .sram_rdata(sram_rdata), .sram_rresp(sram_rresp), .sram_rlast(sram_rlast),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .rd_busy(rd_busy), .rlast_err(rlast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle with requests already driven; returns in the IDLE cycle after the last beat.
    task automatic run_txn(input string tag, input logic exp_lsu, input logic [31:0] exp_addr,
                           input int nbeats, input logic keep_ifu, input logic keep_lsu);
        #2;
        check_output({tag, "_idle_busy"}, rd_busy, 1'b0);
        check_output({tag, "_idle_err"}, rlast_err, 1'b0);
        next_cycle();
        sram_arready = 1'b1;
        #2;
        check_output({tag, "_arvalid"}, sram_arvalid, 1'b1);
        check_output({tag, "_araddr"}, sram_araddr, exp_addr);
        check_output({tag, "_arlen"}, sram_arlen, 32'(nbeats - 1));
        check_output({tag, "_ifu_arready"}, ifu_arready, !exp_lsu);
        check_output({tag, "_lsu_arready"}, lsu_arready, exp_lsu);
        next_cycle();
        sram_arready = 1'b0;
        ifu_arvalid  = keep_ifu;
        lsu_arvalid  = keep_lsu;
        for (int i = 0; i < nbeats; i++) begin
            sram_rvalid = 1'b1;
            sram_rdata  = exp_addr + 32'(i);
            sram_rresp  = 2'(i);
            sram_rlast  = (i == nbeats - 1);
            #2;
            check_output({tag, "_rvalid"}, exp_lsu ? lsu_rvalid : ifu_rvalid, 1'b1);
            check_output({tag, "_other_rvalid"}, exp_lsu ? ifu_rvalid : lsu_rvalid, 1'b0);
            check_output({tag, "_rdata"}, exp_lsu ? lsu_rdata : ifu_rdata, exp_addr + 32'(i));
            check_output({tag, "_rresp"}, exp_lsu ? lsu_rresp : ifu_rresp, 32'(i % 4));
            check_output({tag, "_rlast"}, exp_lsu ? lsu_rlast : ifu_rlast, (i == nbeats - 1));
            check_output({tag, "_sram_rready"}, sram_rready, 1'b1);
            check_output({tag, "_arready_data"}, {ifu_arready, lsu_arready}, 2'b00);
            check_output({tag, "_beat_err"}, rlast_err, 1'b0);
            next_cycle();
        end
        sram_rvalid = 1'b0;
        sram_rlast  = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset_n = 1'b0;
        ifu_arvalid = 0; ifu_araddr = 0; ifu_arlen = 0; ifu_arsize = 3'd2; ifu_rready = 1;
        lsu_arvalid = 0; lsu_araddr = 0; lsu_arlen = 0; lsu_arsize = 3'd2; lsu_rready = 1;
        sram_arready = 0; sram_rvalid = 0; sram_rdata = 0; sram_rresp = 0; sram_rlast = 0;
        lsu_awvalid = 0; lsu_awready = 0; lsu_bvalid = 0; lsu_bready = 0;
        #3;
        check_output("rst_busy", rd_busy, 1'b0);
        check_output("rst_arvalid", sram_arvalid, 1'b0);
        check_output("rst_rready", sram_rready, 1'b0);
        check_output("rst_err", rlast_err, 1'b0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;

        // IFU-only single beat
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_arlen = 8'd0;
        #2;
        check_output("t1_idle_arvalid", sram_arvalid, 1'b0);
        check_output("t1_idle_busy", rd_busy, 1'b0);
        next_cycle();
        sram_arready = 1;
        #2;
        check_output("t1_araddr", sram_araddr, 32'h8000_0000);
        check_output("t1_ifu_arready", ifu_arready, 1'b1);
        check_output("t1_lsu_rvalid_addr", lsu_rvalid, 1'b0);
        next_cycle();
        sram_arready = 0; ifu_arvalid = 0;
        sram_rvalid = 1; sram_rdata = 32'hDEAD_BEEF; sram_rlast = 1;
        #2;
        check_output("t1_rvalid", ifu_rvalid, 1'b1);
        check_output("t1_rdata", ifu_rdata, 32'hDEAD_BEEF);
        check_output("t1_lsu_rvalid", lsu_rvalid, 1'b0);
        check_output("t1_lsu_rdata", lsu_rdata, 32'h0);
        next_cycle();
        sram_rvalid = 0; sram_rlast = 0;
        #2;
        check_output("t1_back_idle", rd_busy, 1'b0);
        check_output("t1_rvalid_done", ifu_rvalid, 1'b0);

        // Simultaneous requests after reset alternate IFU, LSU, IFU, LSU
        next_cycle();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0100; ifu_arlen = 8'd0;
        lsu_arvalid = 1; lsu_araddr = 32'h9000_0200; lsu_arlen = 8'd0;
        run_txn("t2_ifu0", 1'b0, 32'h8000_0100, 1, 1'b1, 1'b1);
        run_txn("t2_lsu0", 1'b1, 32'h9000_0200, 1, 1'b1, 1'b1);
        run_txn("t2_ifu1", 1'b0, 32'h8000_0100, 1, 1'b1, 1'b1);
        run_txn("t2_lsu1", 1'b1, 32'h9000_0200, 1, 1'b0, 1'b0);

        // LSU 4-beat burst with an IFU request raised during the burst
        lsu_arvalid = 1; lsu_araddr = 32'h9000_1000; lsu_arlen = 8'd3;
        ifu_araddr = 32'h8000_2000; ifu_arlen = 8'd0;
        run_txn("t3_lsu_burst", 1'b1, 32'h9000_1000, 4, 1'b1, 1'b0);
        run_txn("t3_ifu_after", 1'b0, 32'h8000_2000, 1, 1'b0, 1'b0);

        // Outstanding write holds the LSU off; IFU is served meanwhile
        lsu_awvalid = 1; lsu_awready = 1;
        #2;
        check_output("t4_aw_idle", rd_busy, 1'b0);
        next_cycle();
        lsu_awvalid = 0; lsu_awready = 0;
        lsu_arvalid = 1; lsu_araddr = 32'h9000_3000; lsu_arlen = 8'd0;
        ifu_arvalid = 1; ifu_araddr = 32'h8000_3000; ifu_arlen = 8'd0;
        run_txn("t4_ifu", 1'b0, 32'h8000_3000, 1, 1'b0, 1'b1);
        #2;
        check_output("t4_lsu_held0", rd_busy, 1'b0);
        next_cycle();
        lsu_bvalid = 1; lsu_bready = 1;
        #2;
        check_output("t4_lsu_held1", rd_busy, 1'b0);
        next_cycle();
        lsu_bvalid = 0; lsu_bready = 0;
        run_txn("t4_lsu", 1'b1, 32'h9000_3000, 1, 1'b0, 1'b0);

        // B with no writes outstanding must not wrap the counter
        lsu_bvalid = 1; lsu_bready = 1;
        next_cycle();
        lsu_bvalid = 0; lsu_bready = 0;
        lsu_arvalid = 1; lsu_araddr = 32'h9000_4000; lsu_arlen = 8'd0;
        run_txn("t7_wr_sat0", 1'b1, 32'h9000_4000, 1, 1'b0, 1'b0);

        // Early RLAST: arlen=1 but RLAST on the first beat
        ifu_arvalid = 1; ifu_araddr = 32'h8000_5000; ifu_arlen = 8'd1;
        next_cycle();
        sram_arready = 1;
        #2;
        check_output("t5a_addr_busy", rd_busy, 1'b1);
        next_cycle();
        sram_arready = 0; ifu_arvalid = 0;
        sram_rvalid = 1; sram_rlast = 1; sram_rdata = 32'h1234_5678;
        #2;
        check_output("t5a_rlast", ifu_rlast, 1'b1);
        check_output("t5a_err_before", rlast_err, 1'b0);
        next_cycle();
        sram_rvalid = 0; sram_rlast = 0;
        #2;
        check_output("t5a_err_pulse", rlast_err, 1'b1);
        check_output("t5a_idle", rd_busy, 1'b0);
        next_cycle();
        #2;
        check_output("t5a_err_clear", rlast_err, 1'b0);

        // Missing RLAST: arlen=0, first beat has RLAST low, block waits for RLAST
        next_cycle();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_6000; ifu_arlen = 8'd0;
        next_cycle();
        sram_arready = 1;
        next_cycle();
        sram_arready = 0; ifu_arvalid = 0;
        sram_rvalid = 1; sram_rlast = 0; sram_rdata = 32'hCAFE_0001;
        next_cycle();
        sram_rvalid = 0;
        #2;
        check_output("t5b_err_pulse", rlast_err, 1'b1);
        check_output("t5b_still_data", rd_busy, 1'b1);
        next_cycle();
        sram_rvalid = 1; sram_rlast = 1; sram_rdata = 32'hCAFE_0002;
        #2;
        check_output("t5b_err_clear", rlast_err, 1'b0);
        check_output("t5b_rvalid", ifu_rvalid, 1'b1);
        next_cycle();
        sram_rvalid = 0; sram_rlast = 0;
        #2;
        check_output("t5b_idle", rd_busy, 1'b0);
        check_output("t5b_no_err", rlast_err, 1'b0);

        // Asynchronous reset in the middle of a burst
        next_cycle();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_7000; ifu_arlen = 8'd3;
        next_cycle();
        sram_arready = 1;
        next_cycle();
        sram_arready = 0; ifu_arvalid = 0;
        sram_rvalid = 1; sram_rlast = 0; sram_rdata = 32'h5555_AAAA;
        #2;
        check_output("t6_pre_rvalid", ifu_rvalid, 1'b1);
        next_cycle();
        #1;
        reset_n = 1'b0;
        #1;
        check_output("t6_rst_rvalid", ifu_rvalid, 1'b0);
        check_output("t6_rst_rdata", ifu_rdata, 32'h0);
        check_output("t6_rst_busy", rd_busy, 1'b0);
        check_output("t6_rst_rready", sram_rready, 1'b0);
        sram_rvalid = 0;
        next_cycle();
        reset_n = 1'b1;
        ifu_arvalid = 1; ifu_araddr = 32'h8000_8000; ifu_arlen = 8'd0;
        lsu_arvalid = 1; lsu_araddr = 32'h9000_8000; lsu_arlen = 8'd0;
        run_txn("t6_tie_ifu", 1'b0, 32'h8000_8000, 1, 1'b0, 1'b1);
        run_txn("t6_then_lsu", 1'b1, 32'h9000_8000, 1, 1'b0, 1'b0);

        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
